// File: rtl/obstacle_spawner.sv
// obstacle_spawner -- side-scroller obstacle generator.
// Waits a pseudo-random gap, spawns one obstacle at the right screen edge,
// scrolls it left once per frame tick and retires it at the left edge,
// counting retired obstacles as the score. A collision freezes the game
// until the next start request.
// Optional feature: define OBS_SPEEDUP_EN to raise the scroll step by one
// on every 8th retired obstacle, saturating at STEP_MAX. Without it the
// step is the constant STEP_INIT.
module obstacle_spawner #(
  parameter int SCREEN_W  = 640,
  parameter int STEP_INIT = 2,
  parameter int STEP_MAX  = 8,
  parameter int GAP_MIN   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        collided,
  output logic [10:0] ObsX,
  output logic [6:0]  ObsH,
  output logic [7:0]  ObsW,
  output logic        obs_valid,
  output logic        passed,
  output logic [15:0] score,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_SPAWN,
    S_MOVE,
    S_HALT
  } state_t;

  localparam logic [10:0] SPAWN_X     = 11'(SCREEN_W);
  localparam logic [10:0] STEP_INIT_V = 11'(STEP_INIT);
  localparam logic [7:0]  GAP_MIN_V   = 8'(GAP_MIN);
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [15:0] SCORE_MAX   = 16'hFFFF;

  state_t      state_q, state_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [10:0] obs_x_q, obs_x_d;
  logic [6:0]  obs_h_q, obs_h_d;
  logic [7:0]  obs_w_q, obs_w_d;
  logic        obs_valid_q, obs_valid_d;
  logic        passed_q, passed_d;
  logic [15:0] score_q, score_d;
  logic        halted_q, halted_d;

  logic        lfsr_fb;
  logic [7:0]  gap_load;
  logic [15:0] score_inc;
  logic        score_rolls;
  logic [10:0] step_v;

`ifdef OBS_SPEEDUP_EN
  localparam logic [10:0] STEP_MAX_V = 11'(STEP_MAX);

  logic [10:0] step_q, step_d;

  assign step_v = step_q;
`else
  assign step_v = STEP_INIT_V;
`endif

  // Feedback of the Fibonacci LFSR (taps 16/14/13/11), the new gap length
  // and the saturating score increment are shared by several transitions.
  assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign gap_load    = GAP_MIN_V + 8'(lfsr_q[4:0]);
  assign score_inc   = (score_q == SCORE_MAX) ? score_q : score_q + 16'd1;
  assign score_rolls = (score_q != SCORE_MAX) && (score_inc[2:0] == 3'd0);

  // The random source advances on each frame tick unless the game is frozen.
  always_comb begin
    lfsr_d = lfsr_q;
    if (tick && (state_q != S_HALT)) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end
  end

  // Next-state and datapath updates for the spawn / move / retire cycle.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    obs_x_d     = obs_x_q;
    obs_h_d     = obs_h_q;
    obs_w_d     = obs_w_q;
    obs_valid_d = obs_valid_q;
    passed_d    = 1'b0;
    score_d     = score_q;
    halted_d    = halted_q;
`ifdef OBS_SPEEDUP_EN
    step_d      = step_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_GAP;
          gap_cnt_d = gap_load;
          score_d   = 16'd0;
`ifdef OBS_SPEEDUP_EN
          step_d    = STEP_INIT_V;
`endif
        end
      end

      S_GAP: begin
        if (collided) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (tick) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
          if (gap_cnt_q == 8'd1) begin
            state_d = S_SPAWN;
          end
        end
      end

      S_SPAWN: begin
        if (collided) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d     = S_MOVE;
          obs_x_d     = SPAWN_X;
          obs_valid_d = 1'b1;
          case (lfsr_q[1:0])
            2'b00:   begin obs_h_d = 7'd35; obs_w_d = 8'd17; end
            2'b01:   begin obs_h_d = 7'd50; obs_w_d = 8'd25; end
            2'b10:   begin obs_h_d = 7'd35; obs_w_d = 8'd51; end
            default: begin obs_h_d = 7'd50; obs_w_d = 8'd75; end
          endcase
        end
      end

      S_MOVE: begin
        if (collided) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (tick) begin
          if (obs_x_q >= step_v) begin
            obs_x_d = obs_x_q - step_v;
          end else begin
            state_d     = S_GAP;
            obs_x_d     = 11'd0;
            obs_valid_d = 1'b0;
            passed_d    = 1'b1;
            score_d     = score_inc;
            gap_cnt_d   = gap_load;
`ifdef OBS_SPEEDUP_EN
            if (score_rolls && (step_q < STEP_MAX_V)) begin
              step_d = step_q + 11'd1;
            end
`endif
          end
        end
      end

      S_HALT: begin
        if (start) begin
          state_d     = S_GAP;
          gap_cnt_d   = gap_load;
          score_d     = 16'd0;
          obs_valid_d = 1'b0;
          halted_d    = 1'b0;
`ifdef OBS_SPEEDUP_EN
          step_d      = STEP_INIT_V;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any obstacle in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= 8'd0;
      lfsr_q      <= LFSR_SEED;
      obs_x_q     <= 11'd0;
      obs_h_q     <= 7'd0;
      obs_w_q     <= 8'd0;
      obs_valid_q <= 1'b0;
      passed_q    <= 1'b0;
      score_q     <= 16'd0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      lfsr_q      <= lfsr_d;
      obs_x_q     <= obs_x_d;
      obs_h_q     <= obs_h_d;
      obs_w_q     <= obs_w_d;
      obs_valid_q <= obs_valid_d;
      passed_q    <= passed_d;
      score_q     <= score_d;
      halted_q    <= halted_d;
    end
  end

`ifdef OBS_SPEEDUP_EN
  // Scroll step register, only present when the speedup feature is built in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= STEP_INIT_V;
    end else begin
      step_q <= step_d;
    end
  end
`else
  // The rolling indication only matters when the step can change.
  logic unused_roll;
  assign unused_roll = score_rolls;
`endif

  assign ObsX      = obs_x_q;
  assign ObsH      = obs_h_q;
  assign ObsW      = obs_w_q;
  assign obs_valid = obs_valid_q;
  assign passed    = passed_q;
  assign score     = score_q;
  assign halted    = halted_q;

endmodule

// File: doc/obstacle_spawner.md
OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640: obstacle spawn X, the right screen edge.
REQ-002 SHALL have parameter STEP_INIT, default 2: initial scroll step in pixels per frame.
REQ-003 SHALL have parameter STEP_MAX, default 8: step saturation limit.
REQ-004 SHALL have parameter GAP_MIN, default 32: minimum frames between obstacles.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port tick, input, 1 bit: one-cycle frame strobe.
REQ-008 SHALL have port start, input, 1 bit: one-cycle begin/restart request.
REQ-009 SHALL have port collided, input, 1 bit: hit flag from the collision detector.
REQ-010 SHALL have port ObsX, output, 11 bits: obstacle left-edge X.
REQ-011 SHALL have port ObsH, output, 7 bits: obstacle height.
REQ-012 SHALL have port ObsW, output, 8 bits: obstacle width.
REQ-013 SHALL have port obs_valid, output, 1 bit: obstacle on screen.
REQ-014 SHALL have port passed, output, 1 bit: one-cycle pulse when an obstacle retires.
REQ-015 SHALL have port score, output, 16 bits: count of retired obstacles.
REQ-016 SHALL have port halted, output, 1 bit: game frozen after a collision.

Function
REQ-017 SHALL implement states IDLE, GAP, SPAWN, MOVE and HALT.
REQ-018 IDLE: start -> GAP; load gap_cnt = GAP_MIN + lfsr[4:0]; load step = STEP_INIT; clear score.
REQ-019 GAP: each tick decrements gap_cnt; tick with gap_cnt==1 -> SPAWN.
REQ-020 SPAWN (exactly 1 clk, no tick needed): ObsX=SCREEN_W; obs_valid=1; shape from lfsr[1:0] as 00 -> H35/W17, 01 -> H50/W25, 10 -> H35/W51, 11 -> H50/W75; then -> MOVE.
REQ-021 MOVE, tick with ObsX >= step: ObsX -= step.
REQ-022 MOVE, tick with ObsX < step: retire; ObsX=0; obs_valid=0; passed=1 for one clk; score += 1 (saturates at 0xFFFF); new gap_cnt loaded; -> GAP.
REQ-023 collided=1 in GAP, SPAWN or MOVE -> HALT next edge; halted=1; ObsX/ObsH/ObsW/obs_valid/score frozen.
REQ-024 collided SHALL take priority over a simultaneous tick: no move, no retire, no passed.
REQ-025 HALT: collided and tick ignored; start -> GAP with the IDLE load actions, obs_valid=0, halted=0.
REQ-026 start SHALL be ignored in GAP, SPAWN and MOVE.
REQ-027 tick together with start in IDLE: transition only; gap counting begins on the next tick.
REQ-028 lfsr: 16-bit Fibonacci, taps 16/14/13/11, advances once per tick in all states except HALT.
REQ-029 gap_cnt and the shape select SHALL sample the current lfsr value.
REQ-030 passed SHALL be 0 in every cycle except the retire cycle.
REQ-031 Arithmetic: ObsX subtraction SHALL be unsigned 11-bit and never wrap below 0, per REQ-022.

Reset
REQ-032 rst=1 SHALL force immediately, clock-independent: state=IDLE, ObsX=0, ObsH=0, ObsW=0, obs_valid=0, passed=0, score=0, halted=0, step=STEP_INIT, gap_cnt=0, lfsr=0xACE1.
REQ-033 Reset mid-MOVE or mid-HALT SHALL discard the obstacle; start is required to resume.

Configuration
REQ-034 Macro OBS_SPEEDUP_EN defined: step increments by 1 on every 8th retire (score[2:0] rolls to 0), saturating at STEP_MAX.
REQ-035 Macro OBS_SPEEDUP_EN undefined: step SHALL stay at STEP_INIT permanently, with no speedup logic.

Verification
REQ-036 Reset, start with no tick, then ticks -> gap_cnt=33 (32+1); SPAWN after the 33rd tick; ObsX=640; obs_valid=1; {ObsH,ObsW} in the REQ-020 set.
REQ-037 MOVE at ObsX=640, step 2, 10 ticks -> ObsX=620.
REQ-038 MOVE at ObsX=1, step 2, tick -> ObsX=0, obs_valid=0, passed high for 1 clk, score 0->1, state GAP.
REQ-039 MOVE at ObsX=300, collided and tick in the same clk -> halted=1, ObsX stays 300; later ticks change nothing; start -> halted=0, score=0.
REQ-040 8 retires -> step=3 with OBS_SPEEDUP_EN defined, step=2 without; 56 retires with the macro -> step=8 and holds.
REQ-041 rst asserted between clock edges mid-MOVE -> all outputs zero before the next edge; lfsr=0xACE1.
